// File: rtl/fifo_ctrl_if.sv
// Link bundle for the FIFO control stage: request/flag handshake plus the
// register loop to and from fifo_cal.
interface fifo_ctrl_if #(
   parameter int PTR_W = 3,
   parameter int CNT_W = 4
);
   logic             wr_en;
   logic             rd_en;
   logic [PTR_W-1:0] next_head;
   logic [PTR_W-1:0] next_tail;
   logic [CNT_W-1:0] next_data_count;
   logic [2:0]       state;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] data_count;
   logic             full;
   logic             empty;
   logic             wr_ack;
   logic             wr_err;
   logic             rd_ack;
   logic             rd_err;

   // slave is the control stage itself; master is the requester plus fifo_cal
   modport slave (
      input  wr_en, rd_en, next_head, next_tail, next_data_count,
      output state, head, tail, data_count, full, empty,
             wr_ack, wr_err, rd_ack, rd_err
   );

   modport master (
      output wr_en, rd_en, next_head, next_tail, next_data_count,
      input  state, head, tail, data_count, full, empty,
             wr_ack, wr_err, rd_ack, rd_err
   );
endinterface

// File: rtl/fifo_ctrl.sv
// Sequential control stage of the 8-entry FIFO: holds the op state, pointers
// and occupancy, and closes the register loop through fifo_cal.
module fifo_ctrl #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3,
   parameter int CNT_W = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   fifo_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      INIT     = 3'b000,
      WRITE    = 3'b001,
      READ     = 3'b010,
      WR_ERROR = 3'b011,
      RD_ERROR = 3'b100,
      NO_OP    = 3'b101
   } state_t;

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   state_t           state_reg, state_next;
   logic [PTR_W-1:0] head_reg, head_next;
   logic [PTR_W-1:0] tail_reg, tail_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             state_legal;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= INIT;
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   always_comb begin
      state_legal = 1'b0;
      case (state_reg)
         INIT, WRITE, READ, WR_ERROR, RD_ERROR, NO_OP: state_legal = 1'b1;
         default:                                      state_legal = 1'b0;
      endcase
   end

   // next_data_count already includes the op currently in state_reg, so the
   // bound checks below can never let an in-flight op overflow or underflow.
   always_comb begin
      state_next = NO_OP;
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (!state_legal) begin
         state_next = INIT;
      end else begin
         head_next  = bus.next_head;
         tail_next  = bus.next_tail;
         count_next = bus.next_data_count;
         if (bus.wr_en && !bus.rd_en) begin
            state_next = (bus.next_data_count < DEPTH_C) ? WRITE : WR_ERROR;
         end else if (bus.rd_en && !bus.wr_en) begin
            state_next = (bus.next_data_count != '0) ? READ : RD_ERROR;
         end else begin
            state_next = NO_OP;
         end
      end
   end

   // Flags decode registers only, so no combinational path from wr_en/rd_en.
   assign bus.state      = state_reg;
   assign bus.head       = head_reg;
   assign bus.tail       = tail_reg;
   assign bus.data_count = count_reg;
   assign bus.full       = (count_reg == DEPTH_C);
   assign bus.empty      = (count_reg == '0);
   assign bus.wr_ack     = (state_reg == WRITE);
   assign bus.wr_err     = (state_reg == WR_ERROR);
   assign bus.rd_ack     = (state_reg == READ);
   assign bus.rd_err     = (state_reg == RD_ERROR);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: closes the loop with a behavioural fifo_cal and checks
// each ack/err transaction against a queue of hand-computed expectations.
module tb_fifo_ctrl;
   localparam int DEPTH = 8;
   localparam int PTR_W = 3;
   localparam int CNT_W = 4;

   localparam logic [2:0] S_INIT     = 3'b000;
   localparam logic [2:0] S_WRITE    = 3'b001;
   localparam logic [2:0] S_READ     = 3'b010;
   localparam logic [2:0] S_WR_ERROR = 3'b011;
   localparam logic [2:0] S_RD_ERROR = 3'b100;
   localparam logic [2:0] S_NO_OP    = 3'b101;

   logic clk = 1'b0;
   logic reset_n;

   fifo_ctrl_if #(.PTR_W(PTR_W), .CNT_W(CNT_W)) bus ();

   fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Behavioural fifo_cal: applies the op held in state to the registered values.
   always_comb begin
      bus.next_head       = bus.head;
      bus.next_tail       = bus.tail;
      bus.next_data_count = bus.data_count;
      case (bus.state)
         S_WRITE: begin
            bus.next_tail       = bus.tail + 1'b1;
            bus.next_data_count = bus.data_count + 1'b1;
         end
         S_READ: begin
            bus.next_head       = bus.head + 1'b1;
            bus.next_data_count = bus.data_count - 1'b1;
         end
         default: ;
      endcase
   end

   typedef struct packed {
      logic [2:0] st;
      logic [3:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   txn          = 0;

   // {wr_ack, wr_err, rd_ack, rd_err} expected for a given op state
   function automatic logic [3:0] flags_of(input logic [2:0] st);
      case (st)
         S_WRITE:    return 4'b1000;
         S_WR_ERROR: return 4'b0100;
         S_READ:     return 4'b0010;
         S_RD_ERROR: return 4'b0001;
         default:    return 4'b0000;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Monitor: every cycle with an ack/err flag is one completed transaction.
   always @(negedge clk) begin
      exp_t       e;
      logic [3:0] flags;
      flags = {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err};
      if (reset_n === 1'b1 && flags != 4'b0000) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_txn: got state=%0d flags=%b, expected none",
                     bus.state, flags);
         end else begin
            e = exp_q.pop_front();
            txn++;
            $display("[TB] txn %0d: state=%0d count=%0d (expect state=%0d count=%0d)",
                     txn, bus.state, bus.data_count, e.st, e.cnt);
            check("txn_state", int'(bus.state), int'(e.st));
            check("txn_count", int'(bus.data_count), int'(e.cnt));
            check("txn_flags", int'(flags), int'(flags_of(e.st)));
         end
      end
   end

   task automatic step(input logic w, input logic r, input logic push,
                       input logic [2:0] st, input logic [3:0] cnt);
      bus.wr_en = w;
      bus.rd_en = r;
      if (push) exp_q.push_back({st, cnt});
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      reset_n   = 1'b0;
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
   endtask

   initial begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      reset_n   = 1'b1;

      // 1: asynchronous reset before any clock edge
      #1 reset_n = 1'b0;
      #1;
      check("rst_state", int'(bus.state), int'(S_INIT));
      check("rst_head", int'(bus.head), 0);
      check("rst_tail", int'(bus.tail), 0);
      check("rst_count", int'(bus.data_count), 0);
      check("rst_empty", int'(bus.empty), 1);
      check("rst_full", int'(bus.full), 0);
      check("rst_flags", int'({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}), 0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // 2: fill with 9 writes, the ninth overflows
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, S_WRITE, 4'(i));
      step(1'b1, 1'b0, 1'b1, S_WR_ERROR, 4'd8);
      step(1'b0, 1'b0, 1'b0, S_NO_OP, 4'd0);
      check("fill_count", int'(bus.data_count), 8);
      check("fill_full", int'(bus.full), 1);
      check("fill_empty", int'(bus.empty), 0);
      check("fill_tail", int'(bus.tail), 0);
      check("fill_head", int'(bus.head), 0);

      // 3: read from empty
      apply_reset();
      step(1'b0, 1'b1, 1'b1, S_RD_ERROR, 4'd0);
      check("uflow_state", int'(bus.state), int'(S_RD_ERROR));
      check("uflow_rd_err", int'(bus.rd_err), 1);
      step(1'b0, 1'b0, 1'b0, S_NO_OP, 4'd0);
      check("uflow_head", int'(bus.head), 0);
      check("uflow_count", int'(bus.data_count), 0);
      check("uflow_empty", int'(bus.empty), 1);

      // 4: simultaneous write+read with 3 entries
      apply_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, S_WRITE, 4'(i));
      step(1'b1, 1'b1, 1'b0, S_NO_OP, 4'd0);
      check("simul_state", int'(bus.state), int'(S_NO_OP));
      check("simul_count_a", int'(bus.data_count), 3);
      step(1'b0, 1'b0, 1'b0, S_NO_OP, 4'd0);
      check("simul_head", int'(bus.head), 0);
      check("simul_tail", int'(bus.tail), 3);
      check("simul_count_b", int'(bus.data_count), 3);

      // 5: wrap-around, 8 writes, 8 reads, 2 writes
      apply_reset();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, S_WRITE, 4'(i));
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, S_READ, 4'(8 - i));
      step(1'b1, 1'b0, 1'b1, S_WRITE, 4'd0);
      step(1'b1, 1'b0, 1'b1, S_WRITE, 4'd1);
      step(1'b0, 1'b0, 1'b0, S_NO_OP, 4'd0);
      check("wrap_head", int'(bus.head), 0);
      check("wrap_tail", int'(bus.tail), 2);
      check("wrap_count", int'(bus.data_count), 2);
      check("wrap_empty", int'(bus.empty), 0);
      check("wrap_full", int'(bus.full), 0);

      // 6: reset while a write is in flight discards it
      apply_reset();
      step(1'b1, 1'b0, 1'b0, S_WRITE, 4'd0);
      check("midrst_pre_state", int'(bus.state), int'(S_WRITE));
      bus.wr_en = 1'b0;
      reset_n   = 1'b0;
      #1;
      check("midrst_state", int'(bus.state), int'(S_INIT));
      check("midrst_tail", int'(bus.tail), 0);
      check("midrst_count", int'(bus.data_count), 0);
      check("midrst_empty", int'(bus.empty), 1);
      check("midrst_wr_ack", int'(bus.wr_ack), 0);
      #1 reset_n = 1'b1;
      step(1'b1, 1'b0, 1'b1, S_WRITE, 4'd0);
      step(1'b0, 1'b0, 1'b0, S_NO_OP, 4'd0);
      check("midrst_tail_after", int'(bus.tail), 1);
      check("midrst_count_after", int'(bus.data_count), 1);
      check("midrst_head_after", int'(bus.head), 0);

      step(1'b0, 1'b0, 1'b0, S_NO_OP, 4'd0);
      step(1'b0, 1'b0, 1'b0, S_NO_OP, 4'd0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
